// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: request opcode encodings,
// FSM state encoding and the fixed memory word width.
package load_store_unit_pkg;

  // Byte-lane logic is written for a 32-bit data word only.
  localparam int LSU_DATA_W = 32;

  // Request opcodes. Codes 5..7 are illegal and answered with an error.
  typedef enum logic [2:0] {
    LSU_LW  = 3'd0,
    LSU_LB  = 3'd1,
    LSU_LBU = 3'd2,
    LSU_SW  = 3'd3,
    LSU_SB  = 3'd4
  } lsu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_RMW_WR = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_byte_lane_unit.sv
// byte_lane_unit: combinational byte-lane helper for the load/store unit.
//   op         : latched request opcode
//   lane       : byte lane within the word (byte address bits [1:0])
//   word       : word read from memory
//   wbyte      : store byte for SB
//   load_data  : LW word, LB sign-extended byte, LBU zero-extended byte, 0 otherwise
//   merge_data : word with the selected lane replaced by wbyte (SB write data)
module byte_lane_unit
  import load_store_unit_pkg::*;
(
  input  logic [2:0]            op,
  input  logic [1:0]            lane,
  input  logic [LSU_DATA_W-1:0] word,
  input  logic [7:0]            wbyte,
  output logic [LSU_DATA_W-1:0] load_data,
  output logic [LSU_DATA_W-1:0] merge_data
);

  logic [7:0] sel_byte;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and a latch is never inferred.
  always_comb begin
    sel_byte   = word[8*lane +: 8];
    load_data  = '0;
    merge_data = word;
    merge_data[8*lane +: 8] = wbyte;
    case (op)
      LSU_LW:  load_data = word;
      LSU_LB:  load_data = {{24{sel_byte[7]}}, sel_byte};
      LSU_LBU: load_data = {24'h0, sel_byte};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-request-at-a-time initiator for a word-organised data
// memory, adding byte loads (signed/unsigned) and byte stores (read-modify-write).
//   clk, rst          : clock; synchronous active-low reset
//   req_*             : request from execute stage (valid/ready handshake)
//   resp_*            : one-cycle completion pulse with load data and error flag
//   mem_*             : word address, write data, read/write strobes, read data
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_out
);

  lsu_state_e        state_q, state_d;
  logic [2:0]        op_q;
  logic [ADDR_W+1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] word_q;
  logic              err_q;

  logic              req_bad;
  logic              rd_dec, wr_dec;
  logic [DATA_W-1:0] load_data, merge_data;

  // Illegal opcode, or a word access that is not 4-byte aligned.
  assign req_bad = (req_op > LSU_SB) ||
                   (((req_op == LSU_LW) || (req_op == LSU_SW)) && (req_addr[1:0] != 2'b00));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the reset branch is synchronous and comes first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_bad;
      end
      if (state_q == ST_RD) word_q <= mem_data_out;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    rd_dec     = 1'b0;
    wr_dec     = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)               state_d = ST_RESP;
          else if (req_op == LSU_SW) state_d = ST_WR;
          else                       state_d = ST_RD;
        end
      end
      ST_RD: begin
        rd_dec  = 1'b1;
        state_d = (op_q == LSU_SB) ? ST_RMW_WR : ST_RESP;
      end
      ST_WR, ST_RMW_WR: begin
        wr_dec  = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  byte_lane_unit u_lane (
    .op         (op_q),
    .lane       (addr_q[1:0]),
    .word       (word_q),
    .wbyte      (wdata_q[7:0]),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Strobes are gated by rst so a reset landing mid-operation cannot write.
  assign mem_read    = rd_dec & rst;
  assign mem_write   = wr_dec & rst;
  assign mem_address = addr_q[ADDR_W+1:2];
  assign mem_data_in = mem_write ? ((op_q == LSU_SB) ? merge_data : wdata_q) : '0;

  // Stores and errors return zero; load_data is already zero for store ops.
  assign resp_rdata = (resp_valid && !err_q) ? load_data : '0;
  assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a word memory model, a negedge
// monitor that pops a scoreboard of expected responses, and directed steps.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [2:0]        req_op = 3'd0;
  logic [ADDR_W+1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_data_in;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_data_out;

  logic [31:0] mem [1024];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          reads;
    int          writes;
  } exp_t;

  exp_t sb_q[$];
  int   acc_hist[$];
  int   resp_hist[$];

  int n_vec = 0;
  int n_bad = 0;
  int ncyc = 0;
  int acc_n = 0;
  int tr_reads = 0;
  int tr_writes = 0;
  int tot_writes = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_data_out (mem_data_out)
  );

  assign mem_data_out = mem_read ? mem[mem_address] : 32'h0;

  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_data_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: strobe sanity every cycle, response scoring, accept bookkeeping.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (mem_read) tr_reads++;
    if (mem_write) begin
      tr_writes++;
      tot_writes++;
    end
    if (rst) begin
      check("strobe_excl", {31'h0, mem_read & mem_write}, 32'h0);
      if (!mem_write) check("wdata_idle_zero", mem_data_in, 32'h0);
    end
    if (resp_valid) begin
      n_vec++;
      assert (sb_q.size() != 0) else begin
        n_bad++;
        $error("FAIL unexpected_resp: observed resp_valid=1 expected no response");
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        resp_hist.push_back(ncyc);
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        check("latency", 32'(ncyc - acc_n), 32'(e.lat));
        check("read_cycles", 32'(tr_reads), 32'(e.reads));
        check("write_cycles", 32'(tr_writes), 32'(e.writes));
      end
    end
    if (req_valid && req_ready && rst) begin
      acc_n = ncyc;
      acc_hist.push_back(ncyc);
      tr_reads = 0;
      tr_writes = 0;
    end
  end

  task automatic wait_accept(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req_ready;
    end
    check(tag, {31'h0, got}, 32'h1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check(tag, 32'(sb_q.size()), 32'h0);
    sb_q.delete();
  endtask

  task automatic do_req(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                        input int reads, input int writes);
    exp_t e;
    e.rdata = exp_rdata; e.err = exp_err; e.lat = lat; e.reads = reads; e.writes = writes;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    sb_q.push_back(e);
    wait_accept("accept_timeout");
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_drain("resp_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   base_w;
    int   base_a;
    int   base_r;
    exp_t e;

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[5] = 32'h8899AABB;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_mem_read", {31'h0, mem_read}, 32'h0);
    check("rst_mem_write", {31'h0, mem_write}, 32'h0);
    check("rst_mem_address", 32'(mem_address), 32'h0);
    check("rst_mem_data_in", mem_data_in, 32'h0);
    rst = 1'b1;

    // Loads from word 5.
    do_req(LSU_LW,  12'h014, 32'h0, 32'h8899AABB, 1'b0, 2, 1, 0);
    do_req(LSU_LB,  12'h015, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 1, 0);
    do_req(LSU_LBU, 12'h015, 32'h0, 32'h000000AA, 1'b0, 2, 1, 0);
    do_req(LSU_LB,  12'h014, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 1, 0);
    do_req(LSU_LB,  12'h017, 32'h0, 32'hFFFFFF88, 1'b0, 2, 1, 0);
    do_req(LSU_LBU, 12'h016, 32'h0, 32'h00000099, 1'b0, 2, 1, 0);

    // Byte store via read-modify-write, then read back.
    do_req(LSU_SB, 12'h016, 32'h12345677, 32'h0, 1'b0, 3, 1, 1);
    check("sb_mem_word", mem[5], 32'h8877AABB);
    do_req(LSU_LW, 12'h014, 32'h0, 32'h8877AABB, 1'b0, 2, 1, 0);

    // Errors: misaligned SW and illegal opcode.
    do_req(LSU_SW, 12'h022, 32'hDEADBEEF, 32'h0, 1'b1, 1, 0, 0);
    do_req(3'd6,   12'h014, 32'h0,        32'h0, 1'b1, 1, 0, 0);
    do_req(LSU_LW, 12'h016, 32'h0,        32'h0, 1'b1, 1, 0, 0);
    check("err_no_write_word8", mem[8], 32'h0);

    // Byte address wrap: top bits select word 1023.
    do_req(LSU_SW, 12'hFFC, 32'hCAFEF00D, 32'h0, 1'b0, 2, 0, 1);
    check("wrap_mem_word", mem[1023], 32'hCAFEF00D);

    // Back-to-back: req_valid held high across two SW requests.
    base_w = tot_writes;
    base_a = acc_hist.size();
    base_r = resp_hist.size();
    e.rdata = 32'h0; e.err = 1'b0; e.lat = 2; e.reads = 0; e.writes = 1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = LSU_SW; req_addr = 12'h000; req_wdata = 32'h11111111;
    sb_q.push_back(e);
    wait_accept("b2b_accept1_timeout");
    @(posedge clk); #1;
    req_addr = 12'h004; req_wdata = 32'h22222222;
    sb_q.push_back(e);
    wait_accept("b2b_accept2_timeout");
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_drain("b2b_resp_timeout");
    check("b2b_accepts", 32'(acc_hist.size() - base_a), 32'h2);
    if (acc_hist.size() - base_a == 2 && resp_hist.size() - base_r >= 1)
      check("b2b_gap", 32'(acc_hist[base_a+1] - resp_hist[base_r]), 32'h1);
    check("b2b_write_count", 32'(tot_writes - base_w), 32'h2);
    check("b2b_mem0", mem[0], 32'h11111111);
    check("b2b_mem1", mem[1], 32'h22222222);

    // Reset during the RD phase of an SB.
    base_w = tot_writes;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = LSU_SB; req_addr = 12'h016; req_wdata = 32'h000000A5;
    wait_accept("rst_sb_accept_timeout");
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_req_ready", {31'h0, req_ready}, 32'h1);
    check("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("midrst_resp_rdata", resp_rdata, 32'h0);
    check("midrst_resp_err", {31'h0, resp_err}, 32'h0);
    check("midrst_mem_read", {31'h0, mem_read}, 32'h0);
    check("midrst_mem_write", {31'h0, mem_write}, 32'h0);
    check("midrst_mem_address", 32'(mem_address), 32'h0);
    check("midrst_mem_data_in", mem_data_in, 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_no_write", 32'(tot_writes - base_w), 32'h0);
    check("midrst_mem_word", mem[5], 32'h8877AABB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory port: accepts one load/store request at a time from the execute stage and drives the word-organised data memory (word address, write data, read/write strobes).
- Adds byte-addressed access on top of the word-only memory: aligned word loads/stores, signed/unsigned byte loads, and byte stores via read-modify-write.
- Returns the load result and a done/error pulse to the pipeline.

Parameters:
- ADDR_W, 10, word-address width of the data memory; the request byte address is ADDR_W+2 bits.
- DATA_W, 32, memory word width; fixed at 32 for byte-lane logic.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous active-low reset, sampled on posedge clk.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; a request is accepted on a cycle with req_valid && req_ready.
- req_op  in  3  0=LW, 1=LB (sign-extend), 2=LBU (zero-extend), 3=SW, 4=SB; 5-7 illegal.
- req_addr  in  ADDR_W+2  byte address.
- req_wdata  in  32  store data; SB uses bits [7:0].
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors.
- resp_err  out  1  with resp_valid: misaligned word access or illegal op.
- mem_address  out  ADDR_W  word address = req_addr[ADDR_W+1:2].
- mem_data_in  out  32  write data to memory.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe; memory writes on the posedge while high.
- mem_data_out  in  32  read data; combinational from mem_address while mem_read=1.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE; latched op/addr/wdata cleared; req_ready=1 after reset; resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_address=0, mem_data_in=0.
- mem_read and mem_write are decoded from state and ANDed with rst, so a reset asserted mid-operation never produces a memory write at that edge.
- States: IDLE, RD, WR, RMW_WR, RESP.
- IDLE: req_ready=1. On accept, latch op, addr, wdata.
  - Illegal op, or LW/SW with addr[1:0]!=0 -> RESP with err=1. No memory strobe is ever issued for that request.
  - LW/LB/LBU/SB -> RD.
  - SW -> WR.
- RD: mem_read=1 for one cycle; capture mem_data_out at the posedge.
  - Loads -> RESP.
  - SB -> RMW_WR.
- Load extraction: lane = addr[1:0]; byte = word[8*lane+7 : 8*lane].
  - LB sign-extends bit 7 of the byte; LBU zero-extends; LW returns the whole word.
- WR: mem_write=1, mem_data_in=wdata -> RESP.
- RMW_WR: mem_write=1; mem_data_in = captured word with lane addr[1:0] replaced by wdata[7:0], other bytes unchanged -> RESP.
- RESP: resp_valid=1 for exactly one cycle with rdata/err -> IDLE. There is no response backpressure.
- Latency from the accept edge to the resp_valid cycle:
  - LW/LB/LBU/SW: 2 cycles.
  - SB: 3 cycles.
  - Error: 1 cycle.
- Throughput: req_ready is low in RD/WR/RMW_WR/RESP. req_valid during those states is ignored, not queued. Next accept is possible in the cycle after RESP.
- Memory strobes are mutually exclusive. mem_address is held stable from RD through RMW_WR. mem_data_in=0 whenever mem_write=0.
- Top byte-address bits wrap through the ADDR_W word-address field with no range error.

Decomposition:
- Shared package, next to the existing opcode definitions: op encodings (LSU_LW..LSU_SB), FSM state encoding, DATA_W.
- One natural sub-module, byte_lane_unit (combinational): load extraction with sign/zero extend, and store-byte merge.
- The FSM, latches and strobes stay in load_store_unit.

Test Plan:
- After reset: pre-load word 5 = 0x8899AABB. LW addr 0x014 -> resp_valid exactly 2 cycles after accept, rdata=0x8899AABB, err=0, one mem_read cycle, no mem_write.
- Same word: LB addr 0x015 -> 0xFFFFFFAA. LBU addr 0x015 -> 0x000000AA. LB addr 0x014 -> 0xFFFFFFBB. LB addr 0x017 -> 0xFFFFFF88.
- SB addr 0x016, wdata 0x12345677 -> one read cycle, then one write cycle with mem_data_in=0x8877AABB; resp_valid 3 cycles after accept. A following LW 0x014 returns 0x8877AABB.
- SW addr 0x022 (misaligned) and req_op=6 -> resp_err=1 one cycle after accept, rdata=0, no mem_read or mem_write on the bus.
- Hold req_valid high continuously with SW 0x000 then SW 0x004 -> second accepted only in the cycle after the first RESP; exactly two write strobes.
- SB in flight: drive rst=0 during RD -> next cycle state IDLE, all outputs 0, no mem_write ever asserted; memory word unchanged.
